// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: access sizes, boot address and byte-lane helper.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [31:0] STARTADDR = 32'hbfc00000;

  // Byte-lane enables for a store; misaligned accesses are not trapped, the
  // low address bits simply select lanes (size 3 behaves like a word).
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CAP  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Occupancy and pointer updates; an illegal push or pop is dropped.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CAP);
    head     = mem_q[rd_ptr_q];
    do_push  = push & (~full | pop);
    do_pop   = pop & ~empty;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    if (do_push & ~do_pop)      count_d = count_q + CNT_W'(1);
    else if (~do_push & do_pop) count_d = count_q - CNT_W'(1);
  end

  // Storage needs no reset because the occupancy count gates its use.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_sram_like_slave.sv
// Instruction-side SRAM-like slave: accepts fetch requests, drives a
// 1-cycle-latency block RAM and returns responses in acceptance order.
import cpu_bus_pkg::*;

module inst_sram_like_slave #(
  parameter int          ADDR_W          = 16,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          RANDOM_STALL    = 0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic [31:0]       rdata,
  output logic              data_ok,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_v_q, pend_v_d;
  logic             pend_wr_q, pend_wr_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             stall_a, stall_d, handshake;
  logic [31:0]      pend_data, fifo_head;
  logic             fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic             unused_bits;

  // Stall sources: a free-running LFSR when stalls are enabled, otherwise none.
  always_comb begin
    lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    stall_a = 1'b0;
    stall_d = 1'b0;
    if (RANDOM_STALL != 0) begin
      stall_a = lfsr_q[0] & lfsr_q[1];
      stall_d = lfsr_q[2] & lfsr_q[3];
    end
  end

  // Request side: accept while a slot is free and issue straight to the RAM;
  // reset gates everything so outputs drop without waiting for a clock.
  always_comb begin
    addr_ok   = resetn & req & (cnt_q < CNT_MAX) & ~stall_a;
    handshake = addr_ok;
    ram_en    = handshake;
    ram_wen   = (handshake & wr) ? byte_en(size, addr[1:0]) : 4'b0000;
    ram_addr  = addr[ADDR_W+1:2];
    ram_wdata = wdata;
    pend_v_d  = handshake;
    pend_wr_d = handshake & wr;
  end

  // Response side: bypass RAM data when nothing is queued, else serve the
  // FIFO head and park the pending response behind it.
  always_comb begin
    pend_data = pend_wr_q ? 32'h0 : ram_rdata;
    data_ok   = resetn & (~fifo_empty | pend_v_q) & ~stall_d;
    rdata     = 32'h0;
    if (data_ok) rdata = fifo_empty ? pend_data : fifo_head;
    fifo_pop  = data_ok & ~fifo_empty;
    fifo_push = pend_v_q & ~(fifo_empty & data_ok);
    cnt_d     = cnt_q;
    if (handshake & ~data_ok)      cnt_d = cnt_q + CNT_W'(1);
    else if (~handshake & data_ok) cnt_d = cnt_q - CNT_W'(1);
  end

  // Control state; asynchronous reset discards all in-flight work.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      pend_v_q  <= 1'b0;
      pend_wr_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      cnt_q     <= cnt_d;
      pend_v_q  <= pend_v_d;
      pend_wr_q <= pend_wr_d;
      lfsr_q    <= lfsr_d;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (pend_data),
    .head   (fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign unused_bits = ^{addr[31:ADDR_W+2], fifo_full};

endmodule

// File: tb/tb_inst_sram_like_slave.sv
// Bench for inst_sram_like_slave: dut0 runs without stalls, dut1 with LFSR
// stalls and a deeper window. A transaction-level model predicts every cycle.
module tb_inst_sram_like_slave;

   localparam int MAX0 = 2;
   localparam int MAX1 = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] resetnS, reqS, wrS, addrOkS, dataOkS, ramEnS;
   logic [1:0][1:0] sizeS;
   logic [1:0][31:0] addrS, wdataS, rdataS, ramWdataS, ramRdataS;
   logic [1:0][3:0] ramWenS;
   logic [1:0][15:0] ramAddrS;

   logic [1:0] snapAddrOk, snapDataOk, snapRamEn;
   logic [1:0][31:0] snapRdata;
   logic [1:0][3:0] snapWen;
   logic [1:0][15:0] snapRamAddr;

   logic [31:0] ramMem [2][65536];
   logic [31:0] modelMem [2][65536];
   logic [31:0] qData [2][16];
   int qCyc [2][16];
   int qHead [2];
   int qCnt [2];
   logic [15:0] lfsrM [2];
   int cycNum, testsRun, failCount;

   inst_sram_like_slave #(.ADDR_W(16), .MAX_OUTSTANDING(MAX0), .RANDOM_STALL(0), .LFSR_SEED(SEED)) dut0 (
      .clk(clk), .resetn(resetnS[0]), .req(reqS[0]), .wr(wrS[0]), .size(sizeS[0]),
      .addr(addrS[0]), .wdata(wdataS[0]), .addr_ok(addrOkS[0]), .rdata(rdataS[0]),
      .data_ok(dataOkS[0]), .ram_en(ramEnS[0]), .ram_wen(ramWenS[0]), .ram_addr(ramAddrS[0]),
      .ram_wdata(ramWdataS[0]), .ram_rdata(ramRdataS[0]));

   inst_sram_like_slave #(.ADDR_W(16), .MAX_OUTSTANDING(MAX1), .RANDOM_STALL(1), .LFSR_SEED(SEED)) dut1 (
      .clk(clk), .resetn(resetnS[1]), .req(reqS[1]), .wr(wrS[1]), .size(sizeS[1]),
      .addr(addrS[1]), .wdata(wdataS[1]), .addr_ok(addrOkS[1]), .rdata(rdataS[1]),
      .data_ok(dataOkS[1]), .ram_en(ramEnS[1]), .ram_wen(ramWenS[1]), .ram_addr(ramAddrS[1]),
      .ram_wdata(ramWdataS[1]), .ram_rdata(ramRdataS[1]));

   // Block RAM behind each DUT: read-first, 1-cycle latency, byte-lane writes.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (ramEnS[d]) begin
            ramRdataS[d] <= ramMem[d][ramAddrS[d]];
            for (int b = 0; b < 4; b++)
               if (ramWenS[d][b]) ramMem[d][ramAddrS[d]][8*b +: 8] <= ramWdataS[d][8*b +: 8];
         end
      end
   end

   typedef struct {
      logic wr;
      logic [1:0] size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0] expWen;
      logic [15:0] expRamAddr;
      logic [31:0] expRdata;
   } vec_t;

   vec_t vecs [13];

   // Lanes covered by an access of 2^size bytes aligned down to its size.
   function automatic logic [3:0] expWen(input logic w, input logic [1:0] sz, input logic [31:0] a);
      int nBytes, base;
      if (!w) return 4'b0000;
      nBytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      base = int'(a[1:0]) & ~(nBytes - 1);
      return 4'(((1 << nBytes) - 1) << base);
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycNum);
      end
   endtask

   task automatic applyStimulus(input int d, input logic r, input logic w, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd);
      reqS[d] = r;
      wrS[d] = w;
      sizeS[d] = sz;
      addrS[d] = a;
      wdataS[d] = wd;
   endtask

   task automatic resetModel(input int d);
      qCnt[d] = 0;
      qHead[d] = 0;
      lfsrM[d] = SEED;
   endtask

   // One clock cycle: sample both DUTs mid low phase, compare against the
   // model, then advance the model across the rising edge.
   task automatic checkOutput();
      logic expA [2];
      logic expD [2];
      logic sa, sd;
      logic [3:0] be;
      int mx, idx;
      #1;
      snapAddrOk = addrOkS;
      snapDataOk = dataOkS;
      snapRamEn = ramEnS;
      snapRdata = rdataS;
      snapWen = ramWenS;
      snapRamAddr = ramAddrS;
      for (int d = 0; d < 2; d++) begin
         mx = (d == 0) ? MAX0 : MAX1;
         sa = (d == 1) && lfsrM[d][0] && lfsrM[d][1];
         sd = (d == 1) && lfsrM[d][2] && lfsrM[d][3];
         if (!resetnS[d]) begin
            expA[d] = 1'b0;
            expD[d] = 1'b0;
         end else begin
            expA[d] = reqS[d] && (qCnt[d] < mx) && !sa;
            expD[d] = (qCnt[d] > 0) && (qCyc[d][qHead[d]] < cycNum) && !sd;
         end
         checkValue($sformatf("dut%0d addr_ok", d), 32'(addrOkS[d]), 32'(expA[d]));
         checkValue($sformatf("dut%0d data_ok", d), 32'(dataOkS[d]), 32'(expD[d]));
         checkValue($sformatf("dut%0d ram_en", d), 32'(ramEnS[d]), 32'(expA[d]));
         if (expD[d]) checkValue($sformatf("dut%0d rdata", d), rdataS[d], qData[d][qHead[d]]);
         if (expA[d]) begin
            checkValue($sformatf("dut%0d ram_addr", d), 32'(ramAddrS[d]), 32'(addrS[d][17:2]));
            checkValue($sformatf("dut%0d ram_wen", d), 32'(ramWenS[d]), 32'(expWen(wrS[d], sizeS[d], addrS[d])));
            if (wrS[d]) checkValue($sformatf("dut%0d ram_wdata", d), ramWdataS[d], wdataS[d]);
         end
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (!resetnS[d]) begin
            resetModel(d);
         end else begin
            if (expD[d]) begin
               qHead[d] = (qHead[d] + 1) % 16;
               qCnt[d]--;
            end
            if (expA[d]) begin
               idx = (qHead[d] + qCnt[d]) % 16;
               qData[d][idx] = wrS[d] ? 32'h0 : modelMem[d][addrS[d][17:2]];
               qCyc[d][idx] = cycNum;
               qCnt[d]++;
               if (wrS[d]) begin
                  be = expWen(1'b1, sizeS[d], addrS[d]);
                  for (int b = 0; b < 4; b++)
                     if (be[b]) modelMem[d][addrS[d][17:2]][8*b +: 8] = wdataS[d][8*b +: 8];
               end
            end
            lfsrM[d] = {lfsrM[d][0] ^ lfsrM[d][2] ^ lfsrM[d][3] ^ lfsrM[d][5], lfsrM[d][15:1]};
         end
      end
      cycNum++;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] v;
      int guard;
      testsRun = 0;
      failCount = 0;
      cycNum = 0;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 65536; i++) begin
            v = 32'(i) * 32'h9E3779B1;
            if (i == 1) v = 32'hDEADBEEF;
            if (i == 'h40) v = 32'h11223344;
            ramMem[d][i] <= v;
            modelMem[d][i] = v;
         end
         resetModel(d);
      end

      vecs[0]  = '{1'b0, 2'd2, 32'h004, 32'h0,        4'b0000, 16'h01, 32'hDEADBEEF};
      vecs[1]  = '{1'b1, 2'd0, 32'h103, 32'h5A5A5A5A, 4'b1000, 16'h40, 32'h0};
      vecs[2]  = '{1'b0, 2'd2, 32'h100, 32'h0,        4'b0000, 16'h40, 32'h5A223344};
      vecs[3]  = '{1'b1, 2'd1, 32'h102, 32'hA5A5A5A5, 4'b1100, 16'h40, 32'h0};
      vecs[4]  = '{1'b0, 2'd2, 32'h100, 32'h0,        4'b0000, 16'h40, 32'hA5A53344};
      vecs[5]  = '{1'b1, 2'd2, 32'h100, 32'hCAFEF00D, 4'b1111, 16'h40, 32'h0};
      vecs[6]  = '{1'b0, 2'd2, 32'h100, 32'h0,        4'b0000, 16'h40, 32'hCAFEF00D};
      vecs[7]  = '{1'b1, 2'd0, 32'h101, 32'h77777777, 4'b0010, 16'h40, 32'h0};
      vecs[8]  = '{1'b0, 2'd2, 32'h100, 32'h0,        4'b0000, 16'h40, 32'hCAFE770D};
      vecs[9]  = '{1'b1, 2'd1, 32'h100, 32'h12341234, 4'b0011, 16'h40, 32'h0};
      vecs[10] = '{1'b0, 2'd2, 32'h100, 32'h0,        4'b0000, 16'h40, 32'hCAFE1234};
      vecs[11] = '{1'b1, 2'd3, 32'h104, 32'h0BADF00D, 4'b1111, 16'h41, 32'h0};
      vecs[12] = '{1'b0, 2'd2, 32'h104, 32'h0,        4'b0000, 16'h41, 32'h0BADF00D};

      resetnS = 2'b00;
      reqS = '0;
      wrS = '0;
      sizeS = '0;
      addrS = '0;
      wdataS = '0;
      @(negedge clk);
      checkOutput();
      applyStimulus(0, 1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
      checkOutput();
      resetnS = 2'b11;
      applyStimulus(0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
      checkOutput();

      $display("[TB] table vectors");
      for (int i = 0; i < 13; i++) begin
         applyStimulus(0, 1'b1, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
         checkOutput();
         checkValue($sformatf("vec%0d addr_ok", i), 32'(snapAddrOk[0]), 32'h1);
         checkValue($sformatf("vec%0d ram_wen", i), 32'(snapWen[0]), 32'(vecs[i].expWen));
         checkValue($sformatf("vec%0d ram_addr", i), 32'(snapRamAddr[0]), 32'(vecs[i].expRamAddr));
         applyStimulus(0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
         checkOutput();
         checkValue($sformatf("vec%0d data_ok", i), 32'(snapDataOk[0]), 32'h1);
         checkValue($sformatf("vec%0d rdata", i), snapRdata[0], vecs[i].expRdata);
      end

      $display("[TB] back-to-back reads");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1'b1, 1'b0, 2'd2, 32'(i * 4), 32'h0);
         checkOutput();
         checkValue($sformatf("stream%0d addr_ok", i), 32'(snapAddrOk[0]), 32'h1);
         checkValue($sformatf("stream%0d data_ok", i), 32'(snapDataOk[0]), 32'(i > 0));
      end
      applyStimulus(0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
      checkOutput();
      checkValue("stream tail data_ok", 32'(snapDataOk[0]), 32'h1);

      $display("[TB] reset with dut0 response pending");
      applyStimulus(0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
      checkOutput();
      resetnS[0] = 1'b0;
      checkOutput();
      checkValue("async reset addr_ok", 32'(snapAddrOk[0]), 32'h0);
      checkValue("async reset data_ok", 32'(snapDataOk[0]), 32'h0);
      checkValue("async reset ram_en", 32'(snapRamEn[0]), 32'h0);
      checkOutput();
      resetnS[0] = 1'b1;
      applyStimulus(0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
      checkOutput();
      checkOutput();
      applyStimulus(0, 1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
      checkOutput();
      applyStimulus(0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
      checkOutput();
      checkValue("post-reset data_ok", 32'(snapDataOk[0]), 32'h1);
      checkValue("post-reset rdata", snapRdata[0], 32'hDEADBEEF);

      $display("[TB] dut1 sustained reads under stalls");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1, 1'b1, 1'b0, 2'd2, 32'((i % 64) * 4), 32'h0);
         checkOutput();
      end

      $display("[TB] reset with dut1 responses outstanding");
      guard = 0;
      while (qCnt[1] < 2 && guard < 60) begin
         applyStimulus(1, 1'b1, 1'b0, 2'd2, 32'(guard * 4), 32'h0);
         checkOutput();
         guard++;
      end
      checkValue("dut1 reached two outstanding", 32'(qCnt[1] >= 2), 32'h1);
      resetnS[1] = 1'b0;
      checkOutput();
      checkValue("dut1 async reset addr_ok", 32'(snapAddrOk[1]), 32'h0);
      checkValue("dut1 async reset data_ok", 32'(snapDataOk[1]), 32'h0);
      checkOutput();
      resetnS[1] = 1'b1;
      applyStimulus(1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) checkOutput();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         for (int d = 0; d < 2; d++)
            applyStimulus(d, ($urandom % 4) != 0, ($urandom % 3) == 0, 2'($urandom % 4),
                          {22'h0, 6'($urandom % 64), 2'($urandom % 4), 2'($urandom % 4)}, $urandom);
         checkOutput();
      end
      for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
      for (int i = 0; i < 30; i++) checkOutput();

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
